act_lut_interp_pipe: RTL and testbench

- Parametrised successor to the fixed 8-bit tanh lookup. A single runtime-programmable half-table supplies both tanh and sigmoid.
- Uses odd symmetry: tanh(-x) = -tanh(x).
- Uses linear interpolation between adjacent table entries.
- 3-stage valid/ready pipeline. Sits between the MAC array output and the next layer's input buffer.

---
 rtl/act_lut_interp_pipe.sv | 164 ++++++++++++++++
 tb/tb_act_lut_interp_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_lut_interp_pipe.sv
// Three-stage tanh/sigmoid unit: odd-symmetric half-table lookup with linear interpolation.
// Define ACT_LUT_SIGMOID_EN to honour in_func (sigmoid); otherwise the output is always tanh.
module act_lut_interp_pipe #(
    parameter int IN_W    = 8,
    parameter int IN_FRAC = 5,
    parameter int OUT_W   = 8,
    parameter int ADDR_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_x,
    input  logic                    in_func,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_y,
    input  logic                    tbl_we,
    input  logic [ADDR_W:0]         tbl_addr,
    input  logic [OUT_W-2:0]        tbl_data
);
    localparam int FB    = IN_W - 1 - ADDR_W;
    localparam int DEPTH = (1 << ADDR_W) + 1;
    localparam int PW    = OUT_W + FB + 2;
    localparam int unused_in_frac = IN_FRAC;
    localparam logic [ADDR_W:0] MAX_ADDR = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W+1)'(1);
    localparam logic signed [IN_W-1:0] MIN_X = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-2:0] MAG_ONE = {{(IN_W-2){1'b0}}, 1'b1};
`ifdef ACT_LUT_SIGMOID_EN
    localparam logic signed [PW-1:0] SIG_BIAS = PW'(1 << (OUT_W-2));
`endif

    logic advance;

    logic [OUT_W-2:0] tbl [DEPTH];

    logic signed [IN_W-1:0] xs;
    logic [IN_W-2:0]        mag;

    logic              s1_valid;
    logic              s1_sign;
    logic [ADDR_W-1:0] s1_idx;
    logic [FB-1:0]     s1_frac;
    logic [ADDR_W:0]   rd_lo;
    logic [ADDR_W:0]   rd_hi;

    logic              s2_valid;
    logic              s2_sign;
    logic [FB-1:0]     s2_frac;
    logic [OUT_W-2:0]  s2_t0;
    logic [OUT_W-2:0]  s2_t1;

`ifdef ACT_LUT_SIGMOID_EN
    logic s1_func;
    logic s2_func;
`else
    logic unused_func;
    assign unused_func = in_func;
`endif

    logic signed [PW-1:0]   t0_ext;
    logic signed [PW-1:0]   t1_ext;
    logic signed [PW-1:0]   frac_ext;
    logic signed [PW-1:0]   diff;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   interp;
    logic signed [PW-1:0]   signed_y;
    logic signed [PW-1:0]   res;
    logic [OUT_W-1:0]       y_next;
    logic [PW-OUT_W-1:0]    unused_res_hi;

    // Every stage moves together whenever the output slot is free or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Table is write-only from the side port; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (tbl_we && tbl_addr <= MAX_ADDR) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    // Magnitude with saturation of the most negative input.
    always_comb begin
`ifdef ACT_LUT_SIGMOID_EN
        xs = in_func ? (in_x >>> 1) : in_x;
`else
        xs = in_x;
`endif
        if (xs == MIN_X) begin
            mag = '1;
        end else if (xs[IN_W-1]) begin
            mag = ~xs[IN_W-2:0] + MAG_ONE;
        end else begin
            mag = xs[IN_W-2:0];
        end
    end

    assign rd_lo = {1'b0, s1_idx};
    assign rd_hi = rd_lo + ADDR_ONE;

    // Interpolate on the magnitude, then restore sign and optionally remap to sigmoid.
    always_comb begin
        t0_ext   = $signed({{(PW-OUT_W+1){1'b0}}, s2_t0});
        t1_ext   = $signed({{(PW-OUT_W+1){1'b0}}, s2_t1});
        frac_ext = $signed({{(PW-FB){1'b0}}, s2_frac});
        diff     = t1_ext - t0_ext;
        prod     = diff * frac_ext;
        interp   = t0_ext + (prod >>> FB);
        signed_y = s2_sign ? -interp : interp;
`ifdef ACT_LUT_SIGMOID_EN
        res      = s2_func ? (SIG_BIAS + (signed_y >>> 1)) : signed_y;
`else
        res      = signed_y;
`endif
        y_next        = res[OUT_W-1:0];
        unused_res_hi = res[PW-1:OUT_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_idx    <= '0;
            s1_frac   <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_frac   <= '0;
            s2_t0     <= '0;
            s2_t1     <= '0;
`ifdef ACT_LUT_SIGMOID_EN
            s1_func   <= 1'b0;
            s2_func   <= 1'b0;
`endif
            out_valid <= 1'b0;
            out_y     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= xs[IN_W-1];
                s1_idx  <= mag[IN_W-2 -: ADDR_W];
                s1_frac <= mag[FB-1:0];
`ifdef ACT_LUT_SIGMOID_EN
                s1_func <= in_func;
`endif
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_frac <= s1_frac;
                s2_t0   <= tbl[rd_lo];
                s2_t1   <= tbl[rd_hi];
`ifdef ACT_LUT_SIGMOID_EN
                s2_func <= s1_func;
`endif
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_y <= y_next;
            end
        end
    end
endmodule

// File: tb/tb_act_lut_interp_pipe.sv
// Randomised and directed bench for act_lut_interp_pipe against an arithmetic reference model.
module tb_act_lut_interp_pipe;
    localparam int DEPTH = 17;
`ifdef ACT_LUT_SIGMOID_EN
    localparam bit SIG_EN   = 1'b1;
    localparam int SIG_24   = 86;
    localparam int SIG_M128 = 3;
    localparam int SIG_0    = 64;
`else
    localparam bit SIG_EN   = 1'b0;
    localparam int SIG_24   = 81;
    localparam int SIG_M128 = -127;
    localparam int SIG_0    = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_x = '0;
    logic              in_func = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] out_y;
    logic              tbl_we = 1'b0;
    logic [4:0]        tbl_addr = '0;
    logic [6:0]        tbl_data = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int tbl_model [DEPTH];
    int tanh_init [DEPTH] = '{0, 31, 59, 81, 97, 108, 115, 120, 122, 124, 125, 126, 126, 127, 127, 127, 127};

    typedef struct {
        int exp;
        int lit;
        bit has_lit;
        int acc;
        bit chk_lat;
    } item_t;

    item_t sb [$];
    bit    lat_mode = 1'b0;
    bit    rand_rdy = 1'b0;
    int    cur_lit = 0;
    bit    cur_has_lit = 1'b0;
    bit    prev_stall = 1'b0;
    int    prev_y = 0;
    bit    head_seen = 1'b0;

    act_lut_interp_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_func   (in_func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(string name, int act);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s: observed %0d, expected none (cycle %0d)", name, act, cyc);
    endtask

    function automatic int floorDiv(int a, int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // tanh(x) from the half table: mirror negatives, interpolate within 8-step cells.
    function automatic int model(int x, bit f);
        int xs, m, idx, fr, y, t;
        xs = (f && SIG_EN) ? floorDiv(x, 2) : x;
        m = (xs < 0) ? -xs : xs;
        if (m > 127) m = 127;
        idx = m / 8;
        fr  = m % 8;
        y = tbl_model[idx] + floorDiv((tbl_model[idx+1] - tbl_model[idx]) * fr, 8);
        t = (xs < 0) ? -y : y;
        return (f && SIG_EN) ? 64 + floorDiv(t, 2) : t;
    endfunction

    // Scoreboard: record accepted samples, compare each retired result in order.
    always @(negedge clk) begin
        item_t it;
        if (!reset) begin
            sb.delete();
            prev_stall = 1'b0;
            head_seen  = 1'b0;
        end else begin
            checkOutput("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (prev_stall) begin
                checkOutput("hold_valid", int'(out_valid), 1);
                checkOutput("hold_y", int'(out_y), prev_y);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    failNow("spurious_out", int'(out_y));
                end else begin
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        if (sb[0].chk_lat) checkOutput("latency", cyc - sb[0].acc, 2);
                    end
                    if (out_ready) begin
                        it = sb.pop_front();
                        checkOutput("out_y", int'(out_y), it.exp);
                        if (it.has_lit) checkOutput("out_y_lit", int'(out_y), it.lit);
                        head_seen = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                it.exp     = model(int'(in_x), in_func);
                it.lit     = cur_lit;
                it.has_lit = cur_has_lit;
                it.acc     = cyc + 1;
                it.chk_lat = lat_mode;
                sb.push_back(it);
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = int'(out_y);
        end
    end

    task automatic setRdy();
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic applyStimulus(int x, bit f, int lit, bit has_lit);
        int guard;
        bit acc;
        guard = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_x = 8'(x);
        in_func = f;
        cur_lit = lit;
        cur_has_lit = has_lit;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            setRdy();
        end
        in_valid = 1'b0;
        if (!acc) failNow("accept_timeout", x);
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            setRdy();
        end
    endtask

    task automatic writeTbl(int addr, int data);
        tbl_we = 1'b1;
        tbl_addr = 5'(addr);
        tbl_data = 7'(data);
        if (addr < DEPTH) tbl_model[addr] = data;
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        #12;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_y", int'(out_y), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < DEPTH; k++) writeTbl(k, tanh_init[k]);

        checkOutput("pin_12", model(12, 1'b0), 45);
        checkOutput("pin_m128", model(-128, 1'b0), -127);
        checkOutput("pin_sig24", model(24, 1'b1), SIG_24);

        // Back-to-back tanh samples with exact latency.
        out_ready = 1'b1;
        lat_mode = 1'b1;
        applyStimulus(0, 1'b0, 0, 1'b1);
        applyStimulus(8, 1'b0, 31, 1'b1);
        applyStimulus(12, 1'b0, 45, 1'b1);
        applyStimulus(-12, 1'b0, -45, 1'b1);
        applyStimulus(-128, 1'b0, -127, 1'b1);
        applyStimulus(127, 1'b0, 127, 1'b1);
        applyStimulus(24, 1'b1, SIG_24, 1'b1);
        applyStimulus(-128, 1'b1, SIG_M128, 1'b1);
        applyStimulus(0, 1'b1, SIG_0, 1'b1);
        idle(5);

        // Backpressure: five samples, then a four-cycle stall with a sample waiting.
        lat_mode = 1'b0;
        applyStimulus(20, 1'b0, 0, 1'b0);
        applyStimulus(-40, 1'b0, 0, 1'b0);
        applyStimulus(60, 1'b1, 0, 1'b0);
        applyStimulus(-80, 1'b0, 0, 1'b0);
        applyStimulus(100, 1'b0, 0, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_x = 8'sd5;
        in_func = 1'b0;
        cur_has_lit = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("bp_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(5, 1'b0, 0, 1'b0);
        idle(5);

        // Table rewrite while streaming; out-of-range write has no effect.
        in_valid = 1'b1;
        in_x = 8'sd100;
        in_func = 1'b0;
        cur_has_lit = 1'b0;
        writeTbl(1, 40);
        in_valid = 1'b0;
        applyStimulus(8, 1'b0, 40, 1'b1);
        applyStimulus(9, 1'b0, 42, 1'b1);
        idle(4);
        writeTbl(31, 5);
        applyStimulus(127, 1'b0, 127, 1'b1);
        applyStimulus(-120, 1'b0, -127, 1'b1);
        idle(5);

        // Reset with three samples in flight.
        lat_mode = 1'b1;
        applyStimulus(16, 1'b0, 0, 1'b0);
        applyStimulus(32, 1'b0, 0, 1'b0);
        applyStimulus(48, 1'b0, 0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        checkOutput("midrst_out_y", int'(out_y), 0);
        checkOutput("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("postrst_in_ready", int'(in_ready), 1);
        applyStimulus(32, 1'b0, 97, 1'b1);
        idle(5);

        // Random traffic with random gaps and backpressure.
        lat_mode = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            applyStimulus($urandom_range(0, 255) - 128, 1'($urandom_range(0, 1)), 0, 1'b0);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (sb.size() != 0) failNow("drain_timeout", sb.size());
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
